// File: rtl/ctrl_sequencer_pkg.sv
// Shared definitions for the control sequencer: opcode mnemonics, sequencer
// states, instruction field positions and decode helpers.
package ctrl_sequencer_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_LSH  = 4'h2,
    OP_RSH  = 4'h3,
    OP_MOV  = 4'h4,
    OP_XOR  = 4'h5,
    OP_AND  = 4'h6,
    OP_OR   = 4'h7,
    OP_BGE  = 4'h8,
    OP_BNE  = 4'h9,
    OP_RXOR = 4'hA,
    OP_BEQ  = 4'hB,
    OP_NOP  = 4'hC,
    OP_NOP1 = 4'hD,
    OP_NOP2 = 4'hE,
    OP_HLT  = 4'hF
  } op_mne;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WB,
    S_HALT
  } seq_state_e;

  localparam int OPC_MSB = 8;
  localparam int OPC_LSB = 5;
  localparam int RA_MSB  = 4;
  localparam int RA_LSB  = 2;
  localparam int RB_MSB  = 1;
  localparam int RB_LSB  = 0;
  localparam int LUT_MSB = 4;

  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_BGE) || (op == OP_BNE) || (op == OP_BEQ);
  endfunction

  function automatic logic is_write(input logic [3:0] op);
    return (op <= OP_OR) || (op == OP_RXOR);
  endfunction

endpackage

// File: rtl/ctrl_sequencer_branch_lut.sv
// Branch target table: maps the 5-bit immediate of a branch instruction to an
// absolute program address.
module ctrl_sequencer_branch_lut #(
  parameter int PCW = 10
) (
  input  logic [4:0]     idx_i,
  output logic [PCW-1:0] target_o
);

  always_comb begin
    target_o = '0;
    case (idx_i)
      5'd0:  target_o = PCW'(100);  5'd1:  target_o = PCW'(200);
      5'd2:  target_o = PCW'(300);  5'd3:  target_o = PCW'(20);
      5'd4:  target_o = PCW'(400);  5'd5:  target_o = PCW'(500);
      5'd6:  target_o = PCW'(600);  5'd7:  target_o = PCW'(700);
      5'd8:  target_o = PCW'(40);   5'd9:  target_o = PCW'(80);
      5'd10: target_o = PCW'(120);  5'd11: target_o = PCW'(160);
      5'd12: target_o = PCW'(240);  5'd13: target_o = PCW'(320);
      5'd14: target_o = PCW'(480);  5'd15: target_o = PCW'(640);
      5'd16: target_o = PCW'(1);    5'd17: target_o = PCW'(2);
      5'd18: target_o = PCW'(3);    5'd19: target_o = PCW'(1000);
      5'd20: target_o = PCW'(1020); 5'd21: target_o = PCW'(1023);
      5'd22: target_o = PCW'(512);  5'd23: target_o = PCW'(256);
      5'd24: target_o = PCW'(128);  5'd25: target_o = PCW'(64);
      5'd26: target_o = PCW'(32);   5'd27: target_o = PCW'(16);
      5'd28: target_o = PCW'(8);    5'd29: target_o = PCW'(4);
      5'd30: target_o = PCW'(2);    5'd31: target_o = PCW'(0);
      default: target_o = '0;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Three-cycle-per-instruction control sequencer: FETCH presents the PC, EXEC
// decodes the returned word for the ALU, WB writes back and steps the PC.
module ctrl_sequencer
  import ctrl_sequencer_pkg::*;
#(
  parameter int PCW = 10,
  parameter int IW  = 9,
  parameter int RAW = 3,
  parameter int CW  = 16
) (
  input  logic           clk_i,
  input  logic           rstN_i,
  input  logic           start_i,
  input  logic [PCW-1:0] startAddr_i,
  input  logic [IW-1:0]  instIn_i,
  input  logic           branchFlag_i,
  output logic [PCW-1:0] instAddr_o,
  output logic [3:0]     aluOp_o,
  output logic [RAW-1:0] regAddrA_o,
  output logic [RAW-1:0] regAddrB_o,
  output logic [RAW-1:0] regWrAddr_o,
  output logic           regWrEn_o,
  output logic           busy_o,
  output logic           done_o,
  output logic [CW-1:0]  instCount_o
);

  seq_state_e     state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [IW-1:0]  ir_q, ir_d;
  logic           flag_q, flag_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [IW-1:0]  curInst;
  logic [3:0]     opcode;
  logic [RAW-1:0] decA, decB, raField;
  logic [PCW-1:0] lutTarget;

  // The synchronous memory only returns the word during EXEC, so EXEC decodes
  // straight from the bus while WB replays the copy latched at the end of EXEC.
  assign curInst = (state_q == S_EXEC) ? instIn_i : ir_q;
  assign opcode  = curInst[OPC_MSB:OPC_LSB];
  assign raField = RAW'(curInst[RA_MSB:RA_LSB]);
  assign decA    = is_branch(opcode) ? '0 : raField;
  assign decB    = is_branch(opcode) ? RAW'(1) : RAW'(curInst[RB_MSB:RB_LSB]);

  ctrl_sequencer_branch_lut #(.PCW(PCW)) u_branch_lut (
    .idx_i    (ir_q[LUT_MSB:0]),
    .target_o (lutTarget)
  );

  assign instAddr_o  = pc_q;
  assign instCount_o = cnt_q;

  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    flag_d      = flag_q;
    cnt_d       = cnt_q;
    aluOp_o     = '0;
    regAddrA_o  = '0;
    regAddrB_o  = '0;
    regWrAddr_o = '0;
    regWrEn_o   = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;

    unique case (state_q)
      S_IDLE, S_HALT: begin
        done_o = (state_q == S_HALT);
        if (start_i) begin
          pc_d    = startAddr_i;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        busy_o  = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        busy_o     = 1'b1;
        aluOp_o    = opcode;
        regAddrA_o = decA;
        regAddrB_o = decB;
        ir_d       = instIn_i;
        flag_d     = branchFlag_i;
        state_d    = (opcode == OP_HLT) ? S_HALT : S_WB;
      end
      S_WB: begin
        busy_o      = 1'b1;
        aluOp_o     = opcode;
        regAddrA_o  = decA;
        regAddrB_o  = decB;
        regWrEn_o   = is_write(opcode);
        regWrAddr_o = is_write(opcode) ? raField : '0;
        pc_d        = (is_branch(opcode) && flag_q) ? lutTarget : pc_q + PCW'(1);
        cnt_d       = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
        state_d     = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: a program-walking reference model
// predicts every cycle of FETCH/EXEC/WB/HALT for directed and random programs.
module tb_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       rstN;
  logic       start;
  logic [9:0] startAddr;
  logic [8:0] instIn;
  logic       branchFlag;
  logic [9:0] instAddr;
  logic [3:0] aluOp;
  logic [2:0] regAddrA, regAddrB, regWrAddr;
  logic       regWrEn, busy, done;
  logic [15:0] instCount;

  logic       satStart;
  logic [9:0] satStartAddr;
  logic [8:0] satInst;
  logic       satFlag;
  logic [9:0] satInstAddr;
  logic [3:0] satAluOp;
  logic [2:0] satRegA, satRegB, satWrAddr;
  logic       satWrEn, satBusy, satDone;
  logic [5:0] satCount;

  logic [8:0] mem [1024];
  logic [9:0] lutRef [32];
  int checks = 0;
  int errors = 0;
  int modelPc;
  int modelCount;

  always #5 clk = ~clk;

  always @(posedge clk) instIn <= mem[instAddr];

  ctrl_sequencer dut (
    .clk_i(clk), .rstN_i(rstN), .start_i(start), .startAddr_i(startAddr),
    .instIn_i(instIn), .branchFlag_i(branchFlag), .instAddr_o(instAddr),
    .aluOp_o(aluOp), .regAddrA_o(regAddrA), .regAddrB_o(regAddrB),
    .regWrAddr_o(regWrAddr), .regWrEn_o(regWrEn), .busy_o(busy),
    .done_o(done), .instCount_o(instCount)
  );

  // Narrow-counter instance so saturation is reachable in a short run.
  ctrl_sequencer #(.CW(6)) satDut (
    .clk_i(clk), .rstN_i(rstN), .start_i(satStart), .startAddr_i(satStartAddr),
    .instIn_i(satInst), .branchFlag_i(satFlag), .instAddr_o(satInstAddr),
    .aluOp_o(satAluOp), .regAddrA_o(satRegA), .regAddrB_o(satRegB),
    .regWrAddr_o(satWrAddr), .regWrEn_o(satWrEn), .busy_o(satBusy),
    .done_o(satDone), .instCount_o(satCount)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startProgram(input int addr);
    startAddr = 10'(addr);
    start = 1'b1;
    tick();
    start = 1'b0;
    modelPc = addr;
    modelCount = 0;
  endtask

  // Walks one instruction from its FETCH cycle; forceFlag < 0 picks a random flag.
  task automatic runInstr(input int forceFlag, input bit glitch, output bit halted);
    logic [8:0] inst;
    logic [3:0] op;
    logic [2:0] ra, rb;
    bit isBr, isWr, flag;
    inst = mem[modelPc];
    op = inst[8:5];
    ra = inst[4:2];
    rb = {1'b0, inst[1:0]};
    isBr = (op == 4'd8) || (op == 4'd9) || (op == 4'd11);
    isWr = (op <= 4'd7) || (op == 4'd10);
    halted = 1'b0;

    checks++;
    if (instAddr !== 10'(modelPc)) begin
      errors++; $display("[TB] FAIL fetchAddr got %0d want %0d", instAddr, modelPc);
    end
    checks++;
    if ({busy, done, aluOp, regWrEn} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
      errors++; $display("[TB] FAIL fetchCtrl got b%0b d%0b op%0d we%0b want b1 d0 op0 we0", busy, done, aluOp, regWrEn);
    end
    checks++;
    if (instCount !== 16'(modelCount)) begin
      errors++; $display("[TB] FAIL fetchCount got %0d want %0d", instCount, modelCount);
    end
    if (glitch && $urandom_range(0, 2) == 0) begin
      start = 1'b1; startAddr = 10'($urandom);
    end
    tick();
    start = 1'b0;

    checks++;
    if ({aluOp, busy, regWrEn, instAddr} !== {op, 1'b1, 1'b0, 10'(modelPc)}) begin
      errors++; $display("[TB] FAIL execCtrl got op%0d b%0b we%0b pc%0d want op%0d b1 we0 pc%0d", aluOp, busy, regWrEn, instAddr, op, modelPc);
    end
    if (op <= 4'd11) begin
      checks++;
      if ({regAddrA, regAddrB} !== (isBr ? {3'd0, 3'd1} : {ra, rb})) begin
        errors++; $display("[TB] FAIL execRegs got %0d,%0d op %0d", regAddrA, regAddrB, op);
      end
    end
    flag = (forceFlag < 0) ? 1'($urandom_range(0, 1)) : forceFlag[0];
    branchFlag = flag;
    if (op == 4'd15 && glitch && $urandom_range(0, 1) == 1) begin
      start = 1'b1; startAddr = 10'($urandom);
    end
    tick();
    start = 1'b0;
    branchFlag = ~flag;

    if (op == 4'd15) begin
      halted = 1'b1;
      checks++;
      if ({busy, done, aluOp, regWrEn, instAddr, instCount} !== {1'b1 ^ 1'b1, 1'b1, 4'd0, 1'b0, 10'(modelPc), 16'(modelCount)}) begin
        errors++; $display("[TB] FAIL haltState got b%0b d%0b op%0d pc%0d cnt%0d want b0 d1 op0 pc%0d cnt%0d", busy, done, aluOp, instAddr, instCount, modelPc, modelCount);
      end
      return;
    end

    checks++;
    if ({regWrEn, regWrAddr, aluOp, busy} !== {isWr, (isWr ? ra : 3'd0), op, 1'b1}) begin
      errors++; $display("[TB] FAIL wbCtrl got we%0b wa%0d op%0d b%0b want we%0b wa%0d op%0d", regWrEn, regWrAddr, aluOp, busy, isWr, isWr ? ra : 3'd0, op);
    end
    if (glitch && $urandom_range(0, 2) == 0) begin
      start = 1'b1; startAddr = 10'($urandom);
    end
    modelPc = (isBr && flag) ? int'(lutRef[inst[4:0]]) : (modelPc + 1) % 1024;
    modelCount = (modelCount >= 65535) ? 65535 : modelCount + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic runToHalt(input int maxInstr, input int forceFlag, input bit glitch);
    bit h;
    h = 1'b0;
    for (int i = 0; i < maxInstr && !h; i++) runInstr(forceFlag, glitch, h);
    if (!h) begin
      checks++; errors++;
      $display("[TB] FAIL haltTimeout got running want halted within %0d instructions", maxInstr);
    end
  endtask

  task automatic test_reset();
    bit clean;
    rstN = 1'b0; start = 1'b0; branchFlag = 1'b0; startAddr = '0;
    tick(); tick();
    checks++;
    if ({instAddr, aluOp, regAddrA, regAddrB, regWrAddr, regWrEn, busy, done, instCount} !== '0) begin
      errors++; $display("[TB] FAIL resetValues got pc%0d op%0d b%0b d%0b want all zero", instAddr, aluOp, busy, done);
    end
    rstN = 1'b1;
    tick();
    mem[40] = {4'd0, 3'd2, 2'd1};
    startProgram(40);
    tick();
    checks++;
    if ({regAddrA, regAddrB, busy} !== {3'd2, 3'd1, 1'b1}) begin
      errors++; $display("[TB] FAIL midExecRegs got %0d,%0d want 2,1", regAddrA, regAddrB);
    end
    #2 rstN = 1'b0;
    #1;
    checks++;
    if ({instAddr, aluOp, regAddrA, regAddrB, regWrAddr, regWrEn, busy, done, instCount} !== '0) begin
      errors++; $display("[TB] FAIL asyncAbort got pc%0d ra%0d b%0b want all zero", instAddr, regAddrA, busy);
    end
    tick(); tick();
    rstN = 1'b1;
    clean = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (regWrEn || busy || instAddr != 10'd0) clean = 1'b0;
    end
    checks++;
    if (clean !== 1'b1) begin
      errors++; $display("[TB] FAIL postResetQuiet got activity want idle");
    end
  endtask

  task automatic test_add_halt();
    mem[5] = {4'd0, 3'd2, 2'd1};
    mem[6] = {4'd15, 5'd0};
    startProgram(5);
    runToHalt(4, -1, 1'b0);
    checks++;
    if (instCount !== 16'd1) begin
      errors++; $display("[TB] FAIL addHaltCount got %0d want 1", instCount);
    end
  endtask

  task automatic test_branch();
    mem[100] = {4'd11, 5'd3};
    mem[20]  = {4'd15, 5'd0};
    mem[101] = {4'd15, 5'd0};
    startProgram(100);
    runToHalt(3, 1, 1'b0);
    checks++;
    if (instAddr !== 10'd20) begin
      errors++; $display("[TB] FAIL beqTaken got %0d want 20", instAddr);
    end
    startProgram(100);
    runToHalt(3, 0, 1'b0);
    checks++;
    if (instAddr !== 10'd101) begin
      errors++; $display("[TB] FAIL beqNotTaken got %0d want 101", instAddr);
    end
  endtask

  task automatic test_wrap();
    mem[1023] = {4'd12, 5'd7};
    mem[0]    = {4'd15, 5'd0};
    startProgram(1023);
    runToHalt(3, -1, 1'b0);
    checks++;
    if ({instAddr, instCount} !== {10'd0, 16'd1}) begin
      errors++; $display("[TB] FAIL pcWrap got pc%0d cnt%0d want pc0 cnt1", instAddr, instCount);
    end
  endtask

  task automatic test_restart();
    mem[300] = {4'd13, 5'd0};
    mem[301] = {4'd4, 3'd5, 2'd3};
    mem[302] = {4'd15, 5'd0};
    startProgram(300);
    runToHalt(5, -1, 1'b1);
  endtask

  task automatic test_random();
    bit h;
    int n;
    for (int iter = 0; iter < 6; iter++) begin
      for (int a = 0; a < 1024; a++) mem[a] = {4'($urandom_range(0, 14)), 5'($urandom)};
      startProgram(int'($urandom_range(0, 1023)));
      n = int'($urandom_range(5, 25));
      for (int k = 0; k < n; k++) runInstr(-1, 1'b1, h);
      mem[modelPc] = {4'd15, 5'($urandom)};
      runToHalt(1, -1, 1'b1);
    end
  endtask

  task automatic test_back_to_back_saturation();
    bit monotonic;
    logic [5:0] prev;
    satStartAddr = 10'd20;
    satInst = {4'd9, 5'd3};
    satFlag = 1'b1;
    satStart = 1'b1;
    tick();
    satStart = 1'b0;
    monotonic = 1'b1;
    prev = satCount;
    for (int i = 0; i < 3 * 40; i++) begin
      tick();
      if (satCount < prev) monotonic = 1'b0;
      prev = satCount;
    end
    checks++;
    if (satCount !== 6'd40) begin
      errors++; $display("[TB] FAIL satMidCount got %0d want 40", satCount);
    end
    for (int i = 0; i < 3 * 30; i++) begin
      tick();
      if (satCount < prev) monotonic = 1'b0;
      prev = satCount;
    end
    checks++;
    if ({satCount, satInstAddr, satBusy, satWrEn} !== {6'd63, 10'd20, 1'b1, 1'b0}) begin
      errors++; $display("[TB] FAIL satHold got cnt%0d pc%0d b%0b want cnt63 pc20 b1", satCount, satInstAddr, satBusy);
    end
    checks++;
    if (monotonic !== 1'b1) begin
      errors++; $display("[TB] FAIL satNoWrap got counter decrease want monotonic");
    end
  endtask

  initial begin
    lutRef = '{10'd100, 10'd200, 10'd300, 10'd20, 10'd400, 10'd500, 10'd600, 10'd700,
               10'd40, 10'd80, 10'd120, 10'd160, 10'd240, 10'd320, 10'd480, 10'd640,
               10'd1, 10'd2, 10'd3, 10'd1000, 10'd1020, 10'd1023, 10'd512, 10'd256,
               10'd128, 10'd64, 10'd32, 10'd16, 10'd8, 10'd4, 10'd2, 10'd0};
    for (int a = 0; a < 1024; a++) mem[a] = {4'd12, 5'd0};
    satStart = 1'b0; satStartAddr = '0; satInst = '0; satFlag = 1'b0;
    test_reset();
    test_add_halt();
    test_branch();
    test_wrap();
    test_restart();
    test_random();
    test_back_to_back_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got no completion want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Multi-cycle control sequencer on the instruction-issue side of the ALU.
- Fetches 9-bit instructions from program memory by PC and decodes them into the ALU opcode plus register-file read/write controls.
- Consumes the ALU branch flag to select the next PC.
- Runs a program from a start pulse until HALT, then signals Done.

Parameters:
- PCW, 10, program-counter / instruction-address width.
- IW, 9, instruction width.
- RAW, 3, register-file address width.
- CW, 16, retired-instruction counter width.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle pulse; begins execution at StartAddr. Honoured only in IDLE or HALT.
- StartAddr  input  PCW  first instruction address.
- InstIn  input  IW  program-memory read data; synchronous memory, valid the cycle after InstAddr is presented.
- BranchFlag  input  1  ALU branch-taken flag, combinational from AluOp and operands.
- InstAddr  output  PCW  program-memory address, equals PC.
- AluOp  output  4  ALU opcode (op_mne encoding).
- RegAddrA  output  RAW  register-file read port A, drives ALU InputA.
- RegAddrB  output  RAW  register-file read port B, drives ALU InputB.
- RegWrAddr  output  RAW  register-file write address.
- RegWrEn  output  1  register-file write enable; ALU Out is the write data.
- Busy  output  1  high in FETCH, EXEC and WB.
- Done  output  1  high while in HALT.
- InstCount  output  CW  instructions retired since last Start; saturating.

Behaviour:
- Reset values: state=IDLE, PC=0, IR=0, flag register=0, AluOp=0, RegAddrA/B=0, RegWrAddr=0, RegWrEn=0, Busy=0, Done=0, InstCount=0.
- Reset asserted mid-program aborts immediately to these values; no partial write survives.
- Instruction format: IR[8:5]=opcode, IR[4:2]=ra, IR[1:0]=rb (zero-extended to RAW).
- Opcodes: ADD 0, SUB 1, LSH 2, RSH 3, MOV 4, XOR 5, AND 6, OR 7, BGE 8, BNE 9, RXOR 10, BEQ 11, NOP 12-14, HLT 15.
- States and transitions:
  - IDLE: Start -> PC=StartAddr, InstCount=0, go to FETCH.
  - FETCH: InstAddr=PC; go to EXEC.
  - EXEC: IR captured from InstIn on entry. AluOp=IR[8:5].
    - ALU op or MOV: RegAddrA=ra, RegAddrB=rb.
    - Branch (8, 9, 11): RegAddrA=0, RegAddrB=1, i.e. compare R0 vs R1.
    - BranchFlag registered at end of EXEC.
    - Go to WB, or to HALT if opcode is HLT (PC unchanged, InstCount not incremented).
  - WB: AluOp and read addresses held from EXEC.
    - RegWrEn=1, RegWrAddr=ra for opcodes 0-7 and 10; RegWrEn=0 otherwise.
    - Next PC = branch_lut[IR[4:0]] if branch opcode and registered flag=1, else PC+1.
    - InstCount+=1, saturating at all-ones.
    - Go to FETCH.
  - HALT: Done=1. Start -> same as from IDLE (Done drops the next cycle).
- Every instruction takes exactly 3 cycles (FETCH, EXEC, WB).
- RegWrEn is high only in WB, exactly one cycle per writing instruction.
- Outside EXEC and WB: AluOp=0, RegAddrA/B=0.
- PC+1 wraps modulo 2^PCW (max address -> 0).
- Start while Busy is ignored.
- Start coincident with the HLT decode in EXEC is ignored; the sequencer still enters HALT.
- NOP opcodes: no write, PC+1, counted as retired.

Decomposition:
- definitions package:
  - op_mne extended with NOP 12-14 (or a single NOP constant) and HLT=4'hF.
  - Sequencer state enum.
  - Opcode field position localparams.
  - is_branch/is_write helper functions.
- Sub-module branch_lut: combinational, 32 entries of PCW bits, indexed by IR[4:0], contents from a case table.

Test Plan:
- Reset mid-EXEC of ADD -> all outputs at reset values within the same cycle as Reset falls; no RegWrEn pulse after release.
- Start with StartAddr=5; program ADD r2,r1 then HLT -> InstAddr 5,6; RegWrEn once with RegWrAddr=2, AluOp=0; Done high on cycle 6; InstCount=1.
- BEQ with lut[3]=20, BranchFlag=1 -> next InstAddr=20. Repeat with BranchFlag=0 -> next InstAddr=PC+1. RegWrEn stays 0 in both.
- PC at 1023 executing NOP -> next InstAddr=0; InstCount increments.
- Start pulsed during FETCH and WB -> ignored; PC sequence unchanged. Start in HALT -> restart at new StartAddr; InstCount cleared.
- Preload InstCount near saturation (test hook or long loop) with BNE looping -> counter holds at 16'hFFFF, no wrap.
